// File: rtl/data_mem_responder.sv
// Data-memory responder for the 16-bit pipelined core: a DEPTH x DATA_W
// word array with fixed wait states and a one-cycle ready/err completion.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (array contents kept)
//   mem_read   load request from the core
//   mem_write  store request from the core
//   address    word address, latched at acceptance
//   wr_data    store data, latched at acceptance
//   rd_data    registered load data, held until the next completed read
//   ready      one-cycle completion pulse
//   busy       high while an accepted request is in flight
//   err        one-cycle pulse with ready when read and write were both set

module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              op_rd;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic last_wait;
    logic illegal;
    logic commit_wr;
    logic commit_rd;

    // WAIT is held for WAIT_CYCLES+1 cycles, so ready follows the
    // acceptance edge by WAIT_CYCLES+1 edges (one edge when WAIT_CYCLES=0).
    assign last_wait = (state == WAIT) && (cnt == 4'd0);
    assign illegal   = op_rd && op_wr;
    assign commit_rd = last_wait && op_rd && !op_wr;
    // Gated by rst so an access aborted by reset never reaches the array.
    assign commit_wr = last_wait && op_wr && !op_rd && !rst;

    // Handshake outputs depend only on registered state.
    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    assign err   = (state == RESP) && illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q <= address;
                        data_q <= wr_data;
                        op_rd  <= mem_read;
                        op_wr  <= mem_write;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        if (commit_rd) begin
                            rd_data <= mem[addr_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array has no reset; it is only touched on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with
// WAIT_CYCLES=2 and one with WAIT_CYCLES=0, each driven independently.

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        rq   [2];
    logic        wq   [2];
    logic [7:0]  ad   [2];
    logic [15:0] wd   [2];
    logic [15:0] rdd  [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        er   [2];

    int checks = 0;
    int errors = 0;
    logic [15:0] last_rd [2];

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst[0]), .mem_read(rq[0]), .mem_write(wq[0]),
        .address(ad[0]), .wr_data(wd[0]), .rd_data(rdd[0]),
        .ready(rdy[0]), .busy(bsy[0]), .err(er[0])
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[1]), .mem_read(rq[1]), .mem_write(wq[1]),
        .address(ad[1]), .wr_data(wd[1]), .rd_data(rdd[1]),
        .ready(rdy[1]), .busy(bsy[1]), .err(er[1])
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input int i, input string name,
                       input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h",
                     i, name, act, exp);
        end
    endtask

    task automatic idle_chk(input int i, input string name);
        chk(i, {name, "_ready"}, 32'(rdy[i]), 0);
        chk(i, {name, "_busy"}, 32'(bsy[i]), 0);
        chk(i, {name, "_err"}, 32'(er[i]), 0);
    endtask

    // One full access; after acceptance the inputs are scrambled to
    // confirm the latched address/data are the ones used.
    task automatic access(input int i, input logic r, input logic w,
                          input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] exp);
        int n;
        int lat;
        logic exp_err;
        lat = (i == 0) ? 3 : 1;
        exp_err = r && w;
        @(negedge clk);
        rq[i] = r; wq[i] = w; ad[i] = a; wd[i] = d;
        @(posedge clk); #1;
        chk(i, "busy_rise", 32'(bsy[i]), 1);
        chk(i, "no_early_ready", 32'(rdy[i]), 0);
        @(negedge clk);
        rq[i] = 1'b0; wq[i] = 1'b0; ad[i] = a + 8'd1; wd[i] = 16'h0000;
        n = 1;
        while (!rdy[i] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(i, "latency", 32'(n - 1), 32'(lat));
        chk(i, "ready_busy", 32'(bsy[i]), 1);
        chk(i, "err", 32'(er[i]), 32'(exp_err));
        if (r && !w) last_rd[i] = exp;
        chk(i, "rd_data", 32'(rdd[i]), 32'(last_rd[i]));
        @(posedge clk); #1;
        idle_chk(i, "after_resp");
        chk(i, "rd_hold", 32'(rdd[i]), 32'(last_rd[i]));
    endtask

    task automatic run_inst(input int i);
        bit seen;
        for (int k = 0; k < 15; k++) begin
            access(i, tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].exp);
        end
        // reset pulse while idle
        @(negedge clk);
        rst[i] = 1'b1;
        #100;
        chk(i, "rst_rd_data", 32'(rdd[i]), 0);
        idle_chk(i, "rst_idle");
        rst[i] = 1'b0;
        last_rd[i] = 16'h0000;
        access(i, 1'b1, 1'b0, 8'h05, 16'h0, 16'hCAFE);
        // reset during WAIT of a write aborts it
        @(negedge clk);
        wq[i] = 1'b1; ad[i] = 8'h40; wd[i] = 16'h7777;
        @(posedge clk); #1;
        chk(i, "abort_busy", 32'(bsy[i]), 1);
        @(negedge clk);
        wq[i] = 1'b0;
        rst[i] = 1'b1;
        #1;
        chk(i, "abort_busy_drop", 32'(bsy[i]), 0);
        chk(i, "abort_rd_data", 32'(rdd[i]), 0);
        last_rd[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[i] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rdy[i] || bsy[i]) seen = 1'b1;
        end
        chk(i, "abort_no_ready", 32'(seen), 0);
        access(i, 1'b1, 1'b0, 8'h40, 16'h0, 16'h3333);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 8'h05, 16'hCAFE, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 8'h20, 16'h1111, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 8'h31, 16'h2222, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 8'h40, 16'h3333, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        tbl[7]  = '{1'b0, 1'b1, 8'hFF, 16'h1234, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'h1234};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 1'b1, 8'h20, 16'hAAAA, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h1111};
        tbl[12] = '{1'b0, 1'b1, 8'h30, 16'h5555, 16'h0000};
        tbl[13] = '{1'b1, 1'b0, 8'h30, 16'h0000, 16'h5555};
        tbl[14] = '{1'b1, 1'b0, 8'h31, 16'h0000, 16'h2222};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rq[i] = 1'b0; wq[i] = 1'b0;
            ad[i] = 8'h00; wd[i] = 16'h0000; last_rd[i] = 16'h0000;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            chk(i, "por_rd_data", 32'(rdd[i]), 0);
            idle_chk(i, "por");
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        run_inst(0);
        run_inst(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
